// File: rtl/ll_ht_res_arb.sv
// Round-robin merge of NUM_SRC hash-table result streams into one registered output
// channel, tagging each result with its source index and counting accepts per source.
module ll_ht_res_arb #(
   parameter  int NUM_SRC = 4,
   parameter  int RES_W   = 64,
   parameter  int CNT_W   = 16,
   localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_SRC-1:0]         s_valid,
   output logic [NUM_SRC-1:0]         s_ready,
   input  logic [NUM_SRC*RES_W-1:0]   s_result,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [RES_W-1:0]           m_result,
   output logic [SRC_W-1:0]           m_src,
   input  logic                       cnt_clr,
   output logic [NUM_SRC*CNT_W-1:0]   cnt_flat
);

   logic                 load_en;
   logic                 found;
   logic                 acc;
   logic [NUM_SRC-1:0]   grant;
   logic [SRC_W-1:0]     grant_idx;
   logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 m_valid_q, m_valid_d;
   logic [RES_W-1:0]     m_result_q, m_result_d;
   logic [SRC_W-1:0]     m_src_q, m_src_d;
   logic [CNT_W-1:0]     cnt_q [NUM_SRC];
   logic [CNT_W-1:0]     cnt_d [NUM_SRC];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Circular first-valid search starting at the round-robin pointer.
   always_comb begin
      logic [SRC_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
         if (!found && s_valid[idx]) begin
            found        = 1'b1;
            grant[idx]   = 1'b1;
            grant_idx    = idx;
         end
      end
   end

   assign load_en = !m_valid_q || m_ready;
   assign acc     = load_en && found;
   assign s_ready = (rst_n && load_en) ? grant : '0;

   always_comb begin
      m_valid_d  = m_valid_q;
      m_result_d = m_result_q;
      m_src_d    = m_src_q;
      rr_ptr_d   = rr_ptr_q;
      if (acc) begin
         m_valid_d  = 1'b1;
         m_result_d = s_result[grant_idx*RES_W +: RES_W];
         m_src_d    = grant_idx;
         rr_ptr_d   = (grant_idx == SRC_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
      end else if (m_ready) begin
         m_valid_d  = 1'b0;
      end
   end

   // Clear beats a same-cycle accept, so that accept goes uncounted.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr)
            cnt_d[i] = '0;
         else if (acc && grant[i])
            cnt_d[i] = sat_inc(cnt_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q  <= 1'b0;
         m_result_q <= '0;
         m_src_q    <= '0;
         rr_ptr_q   <= '0;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      end else begin
         m_valid_q  <= m_valid_d;
         m_result_q <= m_result_d;
         m_src_q    <= m_src_d;
         rr_ptr_q   <= rr_ptr_d;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign m_valid  = m_valid_q;
   assign m_result = m_result_q;
   assign m_src    = m_src_q;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
      assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
   end

   a_onehot_ready: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(s_ready));
   a_hold_stable:  assert property (@(posedge clk) disable iff (!rst_n)
                      (m_valid && !m_ready) |=> ($stable(m_result) && $stable(m_src)));

endmodule

// File: tb/tb_ll_ht_res_arb.sv
// Scoreboard bench for ll_ht_res_arb: directed reset/single/fairness/backpressure/counter
// scenarios followed by a long random run against a round-robin reference model.
module tb_ll_ht_res_arb;
   localparam int NUM_SRC = 4;
   localparam int RES_W   = 64;
   localparam int CNT_W   = 2;
   localparam int SRC_W   = 2;
   localparam int MAXC    = (1 << CNT_W) - 1;

   typedef struct {
      int               src;
      logic [RES_W-1:0] data;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NUM_SRC-1:0]       s_valid = '0;
   logic [NUM_SRC-1:0]       s_ready;
   logic [NUM_SRC*RES_W-1:0] s_result;
   logic                     m_valid;
   logic                     m_ready = 1'b1;
   logic [RES_W-1:0]         m_result;
   logic [SRC_W-1:0]         m_src;
   logic                     cnt_clr = 1'b0;
   logic [NUM_SRC*CNT_W-1:0] cnt_flat;

   logic [RES_W-1:0] cur_data [NUM_SRC];
   int               seq   [NUM_SRC];
   int               want  [NUM_SRC];
   int               waitc [NUM_SRC];
   int               mcnt  [NUM_SRC];
   int               rr = 0;
   bit               mv = 1'b0;
   bit               rnd_mode = 1'b0;
   exp_t             sb [$];
   int               total = 0;
   int               bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_res
      assign s_result[g*RES_W +: RES_W] = cur_data[g];
   end

   ll_ht_res_arb #(.NUM_SRC(NUM_SRC), .RES_W(RES_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_result(s_result),
      .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_src(m_src),
      .cnt_clr(cnt_clr), .cnt_flat(cnt_flat));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic new_item(input int i);
      s_valid[i]  = 1'b1;
      cur_data[i] = {8'(i), 24'(seq[i]), 32'($urandom)};
      seq[i]++;
   endtask

   task automatic drive_new();
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!s_valid[i]) begin
            if (rnd_mode ? ($urandom_range(0, 1) == 1) : (want[i] > 0)) begin
               if (!rnd_mode) want[i]--;
               new_item(i);
            end
         end
      end
   endtask

   task automatic model_reset();
      sb.delete();
      mv = 1'b0;
      rr = 0;
      s_valid = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         mcnt[i] = 0; waitc[i] = 0; want[i] = 0;
      end
   endtask

   // One clock: predict and check at the falling edge, then advance stimulus after the rise.
   task automatic cycle();
      logic [NUM_SRC-1:0] eg;
      logic [NUM_SRC-1:0] dacc;
      bit found;
      bit load;
      int gi;
      @(negedge clk);
      load = !mv || m_ready;
      found = 1'b0;
      gi = 0;
      eg = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         int j;
         j = (rr + k) % NUM_SRC;
         if (!found && s_valid[j]) begin
            found = 1'b1;
            gi = j;
         end
      end
      if (found && load) eg[gi] = 1'b1;
      chk("m_valid", 64'(m_valid), 64'(mv));
      chk("s_ready", 64'(s_ready), 64'(eg));
      for (int i = 0; i < NUM_SRC; i++)
         chk($sformatf("cnt%0d", i), 64'(cnt_flat[i*CNT_W +: CNT_W]), 64'(mcnt[i]));
      for (int i = 0; i < NUM_SRC; i++) begin
         if (s_valid[i]) begin
            if (s_ready[i]) begin
               chk($sformatf("wait%0d", i), 64'(waitc[i] <= NUM_SRC - 1), 64'(1));
               waitc[i] = 0;
            end else if (|s_ready) begin
               waitc[i]++;
            end
         end
      end
      dacc = s_valid & s_ready;
      if (found && load) begin
         sb.push_back('{src: gi, data: cur_data[gi]});
         rr = (gi + 1) % NUM_SRC;
         mv = 1'b1;
         if (mcnt[gi] < MAXC) mcnt[gi]++;
      end else if (m_ready) begin
         mv = 1'b0;
      end
      if (cnt_clr)
         for (int i = 0; i < NUM_SRC; i++) mcnt[i] = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++)
         if (dacc[i]) s_valid[i] = 1'b0;
      drive_new();
      if (rnd_mode) begin
         m_ready = ($urandom_range(0, 3) != 0);
         cnt_clr = ($urandom_range(0, 499) == 0);
      end
   endtask

   task automatic drain(input string nm);
      for (int n = 0; n < 80 && ((|s_valid) || m_valid || (sb.size() != 0)); n++) cycle();
      chk(nm, 64'({s_valid, m_valid}), 64'(0));
   endtask

   // Monitor: pops the oldest expected result whenever the output handshake completes.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'(1), 64'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("m_src", 64'(m_src), 64'(e.src));
            chk("m_result", m_result, e.data);
         end
      end
   end

   initial begin
      logic [RES_W-1:0] d1;
      for (int i = 0; i < NUM_SRC; i++) begin
         cur_data[i] = '0; seq[i] = 0;
      end
      model_reset();
      #2;
      chk("rst_m_valid", 64'(m_valid), 64'(0));
      chk("rst_m_result", m_result, 64'(0));
      chk("rst_m_src", 64'(m_src), 64'(0));
      chk("rst_cnt", 64'(cnt_flat), 64'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // single source 2 with 0xA5
      s_valid[2] = 1'b1;
      cur_data[2] = 64'hA5;
      cycle();
      chk("t2_m_valid", 64'(m_valid), 64'(1));
      chk("t2_m_result", m_result, 64'hA5);
      chk("t2_m_src", 64'(m_src), 64'(2));
      chk("t2_cnt2", 64'(cnt_flat[2*CNT_W +: CNT_W]), 64'(1));
      drain("t2_drain");

      // all sources continuously valid
      for (int i = 0; i < NUM_SRC; i++) want[i] = 6;
      drive_new();
      drain("t3_drain");

      // backpressure with src1 and src3 pending
      s_valid[1] = 1'b0;
      new_item(1);
      d1 = cur_data[1];
      cycle();
      m_ready = 1'b0;
      new_item(1);
      new_item(3);
      repeat (5) begin
         cycle();
         chk("t4_hold_src", 64'(m_src), 64'(1));
         chk("t4_hold_res", m_result, d1);
      end
      m_ready = 1'b1;
      cycle();
      chk("t4_next_src", 64'(m_src), 64'(3));
      drain("t4_drain");

      // saturating counter, then clear racing an accept
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      want[0] = 5;
      drive_new();
      drain("t5_drain");
      chk("t5_sat", 64'(cnt_flat[0 +: CNT_W]), 64'(3));
      new_item(0);
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      chk("t5_clr_acc", 64'(cnt_flat[0 +: CNT_W]), 64'(0));
      drain("t5_drain2");
      new_item(0);
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      chk("t5_clr_acc0", 64'(cnt_flat[0 +: CNT_W]), 64'(0));
      drain("t5_drain3");

      // asynchronous reset while the output holds a result
      new_item(0);
      new_item(1);
      cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("t1_m_valid", 64'(m_valid), 64'(0));
      chk("t1_s_ready", 64'(s_ready), 64'(0));
      chk("t1_cnt", 64'(cnt_flat), 64'(0));
      chk("t1_m_result", m_result, 64'(0));
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // random traffic
      rnd_mode = 1'b1;
      repeat (10000) cycle();
      rnd_mode = 1'b0;
      m_ready = 1'b1;
      cnt_clr = 1'b0;
      drain("t6_drain");
      chk("t6_sb_empty", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
